// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the stream_mux N-channel registered multiplexor.
package stream_mux_pkg;

   localparam int unsigned STAT_W      = 16;
   localparam logic [STAT_W-1:0] STAT_MAX = 16'hFFFF;

   localparam int unsigned RR_MODE_SEL = 0;
   localparam int unsigned RR_MODE_RR  = 1;

   // Select/index width: at least one bit even for degenerate channel counts.
   function automatic int unsigned sel_width(input int unsigned channels);
      return (channels > 2) ? int'($clog2(channels)) : 1;
   endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr wins; ptr moves past the winner on advance.
module stream_mux_rr_arbiter
   import stream_mux_pkg::*;
#(
   parameter  int unsigned CHANNELS = 4,
   localparam int unsigned SELW     = sel_width(CHANNELS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CHANNELS-1:0] req,
   input  logic                advance,
   output logic [SELW-1:0]     grant,
   output logic                grant_valid
);

   logic [SELW-1:0] ptr;
   logic [SELW-1:0] idx;

   // Scan upward from ptr with wrap; the first hit is kept.
   always_comb begin
      grant       = '0;
      grant_valid = 1'b0;
      idx         = '0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
         idx = SELW'((32'(ptr) + k) % CHANNELS);
         if (!grant_valid && req[idx]) begin
            grant       = idx;
            grant_valid = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
      end else if (advance) begin
         ptr <= (32'(grant) == CHANNELS - 1) ? '0 : grant + 1'b1;
      end
   end

endmodule

// File: rtl/stream_mux.sv
// Registered N-channel stream multiplexor with valid/ready flow control, select or round-robin.
// Optional per-channel grant counters are enabled with `define STREAM_MUX_STATS_EN.
module stream_mux
   import stream_mux_pkg::*;
#(
   parameter  int unsigned WIDTH    = 16,
   parameter  int unsigned CHANNELS = 4,
   parameter  int unsigned RR_MODE  = RR_MODE_SEL,
   localparam int unsigned SELW     = sel_width(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   input  logic [SELW-1:0]           sel,
   output logic [WIDTH-1:0]          out_data,
   output logic [SELW-1:0]           out_chan,
   output logic                      out_valid,
   input  logic                      out_ready
`ifdef STREAM_MUX_STATS_EN
   ,
   input  logic [SELW-1:0]           stat_sel,
   output logic [STAT_W-1:0]         stat_count
`endif
);

   logic [SELW-1:0]  grant;
   logic             grant_valid;
   logic             can_load;
   logic             valid_g;
   logic             transfer;
   logic [WIDTH-1:0] word;

   assign can_load = !out_valid || out_ready;
   assign transfer = grant_valid && valid_g && can_load && !reset;

   generate
      if (RR_MODE == RR_MODE_RR) begin : g_rr
         logic unused_sel;
         assign unused_sel = ^sel;

         stream_mux_rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
            .clk         (clk),
            .reset       (reset),
            .req         (in_valid),
            .advance     (transfer),
            .grant       (grant),
            .grant_valid (grant_valid)
         );
      end else begin : g_sel
         assign grant       = sel;
         assign grant_valid = (32'(sel) < CHANNELS);
      end
   endgenerate

   // Decode the grant into ready strobe, valid lookup and word select.
   always_comb begin
      in_ready = '0;
      valid_g  = 1'b0;
      word     = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         if (32'(grant) == i) begin
            in_ready[i] = grant_valid && can_load && !reset;
            valid_g     = in_valid[i];
            word        = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
      end else if (transfer) begin
         out_valid <= 1'b1;
         out_data  <= word;
         out_chan  <= grant;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef STREAM_MUX_STATS_EN
   logic [STAT_W-1:0] stat_cnt [CHANNELS];

   // Saturating per-channel grant counters.
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         if (reset) begin
            stat_cnt[i] <= '0;
         end else if (transfer && 32'(grant) == i && stat_cnt[i] != STAT_MAX) begin
            stat_cnt[i] <= stat_cnt[i] + 1'b1;
         end
      end
   end

   always_comb begin
      stat_count = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         if (32'(stat_sel) == i) stat_count = stat_cnt[i];
      end
   end
`endif

endmodule

// File: tb/tb_stream_mux.sv
// Directed bench for stream_mux: select mode (4 and 5 channels) and round-robin mode.
// Grant-counter checks run when STREAM_MUX_STATS_EN is defined.
module tb_stream_mux;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   logic [63:0] s4_data;
   logic [3:0]  s4_valid, s4_ready;
   logic [1:0]  s4_sel, s4_chan;
   logic [15:0] s4_out;
   logic        s4_ov, s4_or;

   logic [79:0] s5_data;
   logic [4:0]  s5_valid, s5_ready;
   logic [2:0]  s5_sel, s5_chan;
   logic [15:0] s5_out;
   logic        s5_ov, s5_or;

   logic [63:0] r_data;
   logic [3:0]  r_valid, r_ready;
   logic [1:0]  r_sel, r_chan;
   logic [15:0] r_out;
   logic        r_ov, r_or;

`ifdef STREAM_MUX_STATS_EN
   logic [1:0]  s4_ssel, r_ssel;
   logic [2:0]  s5_ssel;
   logic [15:0] s4_scnt, s5_scnt, r_scnt;
`endif

   int n_pass  = 0;
   int n_total = 0;

   stream_mux #(.WIDTH(16), .CHANNELS(4), .RR_MODE(0)) u4 (
      .clk(clk), .reset(reset), .in_data(s4_data), .in_valid(s4_valid), .in_ready(s4_ready),
      .sel(s4_sel), .out_data(s4_out), .out_chan(s4_chan), .out_valid(s4_ov), .out_ready(s4_or)
`ifdef STREAM_MUX_STATS_EN
      , .stat_sel(s4_ssel), .stat_count(s4_scnt)
`endif
   );

   stream_mux #(.WIDTH(16), .CHANNELS(5), .RR_MODE(0)) u5 (
      .clk(clk), .reset(reset), .in_data(s5_data), .in_valid(s5_valid), .in_ready(s5_ready),
      .sel(s5_sel), .out_data(s5_out), .out_chan(s5_chan), .out_valid(s5_ov), .out_ready(s5_or)
`ifdef STREAM_MUX_STATS_EN
      , .stat_sel(s5_ssel), .stat_count(s5_scnt)
`endif
   );

   stream_mux #(.WIDTH(16), .CHANNELS(4), .RR_MODE(1)) ur (
      .clk(clk), .reset(reset), .in_data(r_data), .in_valid(r_valid), .in_ready(r_ready),
      .sel(r_sel), .out_data(r_out), .out_chan(r_chan), .out_valid(r_ov), .out_ready(r_or)
`ifdef STREAM_MUX_STATS_EN
      , .stat_sel(r_ssel), .stat_count(r_scnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   // One round-robin cycle: present requests, check the strobe, then the loaded word.
   task automatic rr_step(input logic [3:0] valid, input logic [1:0] exp);
      r_valid = valid;
      #1 check("rr_ready", 32'(r_ready), 32'(4'(4'b0001 << exp)));
      cyc();
      check("rr_chan", 32'(r_chan), 32'(exp));
      check("rr_data", 32'(r_out), 32'(exp));
      check("rr_valid", 32'(r_ov), 32'd1);
   endtask

   initial begin
      reset    = 1'b1;
      s4_or    = 1'b1;  s5_or = 1'b1;  r_or = 1'b1;
      s4_valid = '1;    s5_valid = '1; r_valid = '1;
      s4_sel   = 2'd2;  s5_sel = 3'd0; r_sel = 2'd0;
      s4_data  = {16'h4444, 16'hBEEF, 16'h2222, 16'h1111};
      s5_data  = {16'h5004, 16'h5003, 16'h5002, 16'h5001, 16'h5000};
      r_data   = {16'h0003, 16'h0002, 16'h0001, 16'h0000};
`ifdef STREAM_MUX_STATS_EN
      s4_ssel = 2'd0; s5_ssel = 3'd0; r_ssel = 2'd0;
`endif

      // Reset with every channel requesting
      cyc();
      cyc();
      check("rst_s4_ready", 32'(s4_ready), 32'd0);
      check("rst_s5_ready", 32'(s5_ready), 32'd0);
      check("rst_r_ready",  32'(r_ready),  32'd0);
      check("rst_s4_valid", 32'(s4_ov),    32'd0);
      check("rst_s4_data",  32'(s4_out),   32'd0);
      check("rst_s5_valid", 32'(s5_ov),    32'd0);
      check("rst_r_valid",  32'(r_ov),     32'd0);

      // Select mode: first transfer one cycle after release
      reset    = 1'b0;
      s5_valid = '0;
      r_valid  = '0;
      s4_valid = 4'b0100;
      #1 check("sel_ready", 32'(s4_ready), 32'b0100);
      cyc();
      check("sel_valid", 32'(s4_ov),   32'd1);
      check("sel_data",  32'(s4_out),  32'hBEEF);
      check("sel_chan",  32'(s4_chan), 32'd2);

      // Load 1234 while draining BEEF, then hold it under backpressure
      s4_data[31:16] = 16'h1234;
      s4_sel   = 2'd1;
      s4_valid = 4'b0010;
      #1 check("load_ready", 32'(s4_ready), 32'b0010);
      cyc();
      check("load_data", 32'(s4_out),  32'h1234);
      check("load_chan", 32'(s4_chan), 32'd1);
      s4_or = 1'b0;
      s4_data[31:16] = 16'h5678;
      for (int k = 0; k < 5; k++) begin
         #1 check("stall_ready", 32'(s4_ready), 32'd0);
         cyc();
         check("stall_data",  32'(s4_out), 32'h1234);
         check("stall_valid", 32'(s4_ov),  32'd1);
      end
      s4_or = 1'b1;
      #1 check("unstall_ready", 32'(s4_ready), 32'b0010);
      cyc();
      check("unstall_data",  32'(s4_out), 32'h5678);
      check("unstall_valid", 32'(s4_ov),  32'd1);
      s4_valid = '0;
      cyc();
      check("drain_valid", 32'(s4_ov),   32'd0);
      check("drain_data",  32'(s4_out),  32'h5678);
      check("drain_chan",  32'(s4_chan), 32'd1);

      // Five channels: out-of-range select grants nothing, top channel works
      s5_valid = '1;
      s5_sel   = 3'd5;
      #1 check("s5_oor_ready", 32'(s5_ready), 32'd0);
      cyc();
      check("s5_oor_valid", 32'(s5_ov), 32'd0);
      s5_sel = 3'd4;
      #1 check("s5_top_ready", 32'(s5_ready), 32'b10000);
      cyc();
      check("s5_top_data", 32'(s5_out),  32'h5004);
      check("s5_top_chan", 32'(s5_chan), 32'd4);
      s5_valid = '0;

      // Round-robin fairness with all valid
      rr_step(4'b1111, 2'd0);
      rr_step(4'b1111, 2'd1);
      rr_step(4'b1111, 2'd2);
      rr_step(4'b1111, 2'd3);
      rr_step(4'b1111, 2'd0);
      // Sparse requests: only 1 and 3
      rr_step(4'b1010, 2'd1);
      rr_step(4'b1010, 2'd3);
      rr_step(4'b1010, 2'd1);
      rr_step(4'b1010, 2'd3);
      // Bring ptr to 3, then only channel 0: wraps, ptr moves to 1
      rr_step(4'b1111, 2'd0);
      rr_step(4'b1111, 2'd1);
      rr_step(4'b1111, 2'd2);
      rr_step(4'b0001, 2'd0);
      rr_step(4'b1111, 2'd1);

      // Round-robin stall and drain
      r_or = 1'b0;
      #1 check("rr_stall_ready", 32'(r_ready), 32'd0);
      cyc();
      check("rr_stall_chan",  32'(r_chan), 32'd1);
      check("rr_stall_valid", 32'(r_ov),   32'd1);
      r_or    = 1'b1;
      r_valid = '0;
      cyc();
      check("rr_drain_valid", 32'(r_ov), 32'd0);

      // Reset while holding a word discards it
      s4_sel   = 2'd2;
      s4_valid = 4'b0100;
      s4_or    = 1'b0;
      cyc();
      check("hold_data", 32'(s4_out), 32'hBEEF);
      reset = 1'b1;
      #1 check("midrst_ready", 32'(s4_ready), 32'd0);
      cyc();
      check("midrst_valid", 32'(s4_ov),   32'd0);
      check("midrst_data",  32'(s4_out),  32'd0);
      check("midrst_chan",  32'(s4_chan), 32'd0);
      reset    = 1'b0;
      s4_valid = '0;
      s4_or    = 1'b1;

`ifdef STREAM_MUX_STATS_EN
      // Saturating grant counters
      s4_sel   = 2'd0;
      s4_valid = 4'b0001;
      repeat (3) cyc();
      check("stat_partial", 32'(s4_scnt), 32'd3);
      repeat (69997) @(posedge clk);
      #2;
      s4_valid = '0;
      cyc();
      s4_ssel = 2'd0;
      #1 check("stat_sat", 32'(s4_scnt), 32'hFFFF);
      s4_ssel = 2'd1;
      #1 check("stat_other", 32'(s4_scnt), 32'd0);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      s4_ssel = 2'd0;
      #1 check("stat_rst0", 32'(s4_scnt), 32'd0);
      s4_ssel = 2'd1;
      #1 check("stat_rst1", 32'(s4_scnt), 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/stream_mux.md
Name: stream_mux

Overview:
- Parametrised, registered N-channel successor to the Hack 16-bit 2:1 multiplexor.
- Selects one of CHANNELS input streams and forwards its WIDTH-bit word through a single output register with valid/ready flow control.
- Selection is either external (sel port) or internal round-robin arbitration.
- Sits between multiple Hack data producers (ALU result, memory read, I/O) and a single consumer such as a register load path or bus.

Parameters:
- WIDTH, 16, data word width in bits.
- CHANNELS, 4, number of input streams; legal range 2..16.
- RR_MODE, 0, 0 = select by sel port; 1 = round-robin arbitration (sel ignored).

Ports:
- clk  input  1  single clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel word-present flag.
- in_ready  output  CHANNELS  per-channel accept strobe (at most one bit high).
- sel  input  SELW=max(1,$clog2(CHANNELS))  channel select; used only when RR_MODE=0.
- out_data  output  WIDTH  registered output word.
- out_chan  output  SELW  channel index that supplied out_data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts out_data this cycle.

Behaviour:
- Reset (sampled on the clk edge with reset=1): out_valid=0, out_data=0, out_chan=0, rr pointer=0. in_ready is all-zero while reset=1. Reset mid-transfer discards the held word.
- can_load = !out_valid || out_ready (output register empty, or being drained this cycle).
- RR_MODE=0:
  - Grant g = sel.
  - in_ready[g] = can_load. All other bits are 0.
  - sel >= CHANNELS grants nothing (all in_ready=0).
- RR_MODE=1:
  - Grant g = first i with in_valid[i]=1, searching from ptr upward and wrapping modulo CHANNELS.
  - in_ready[g] = can_load; no grant if no in_valid bit is set.
  - On transfer, ptr <= (g+1) mod CHANNELS; ptr is unchanged when there is no transfer.
- Transfer occurs when in_valid[g] && in_ready[g]. On that clk edge: out_data <= word g, out_chan <= g, out_valid <= 1.
- Drain without load (out_valid && out_ready && no transfer): out_valid <= 0; out_data and out_chan hold their values.
- Stall (out_valid && !out_ready): out_data and out_chan are stable; all in_ready=0.
- Simultaneous drain and load: full throughput, one word per cycle, no bubble.
- Latency: one cycle from input transfer to out_valid.
- in_ready is combinational from in_valid, sel, out_valid, out_ready and ptr. It never depends on in_data.
- Fairness (RR_MODE=1): with all channels continuously valid, grants follow 0,1,...,CHANNELS-1,0,...
- Ordering: words from a single channel are never reordered or duplicated.

Optional Feature:
- Macro: STREAM_MUX_STATS_EN.
- Defined:
  - Adds one 16-bit saturating grant counter per channel, incremented on each transfer from that channel. Counters hold at 16'hFFFF.
  - Adds ports stat_sel (input, SELW bits) and stat_count (output, 16 bits). stat_count is the combinational read of counter[stat_sel], and reads 0 for an out-of-range index.
  - Counters clear on reset.
- Undefined: no counters and no stat ports; datapath behaviour is identical.

Decomposition:
- Package stream_mux_pkg:
  - Function sel_width(CHANNELS).
  - Constants STAT_W=16 and STAT_MAX=16'hFFFF.
  - Localparam RR_MODE_SEL=0 and RR_MODE_RR=1 encodings.
- Sub-module rr_arbiter (CHANNELS):
  - Inputs: req[CHANNELS], advance.
  - Outputs: grant index, grant_valid.
  - Owns ptr and handles wrap-around.
  - Instantiated only when RR_MODE=1 (generate).

Test Plan:
- Reset: assert reset with all in_valid=1 -> in_ready=0, out_valid=0, out_data=16'h0000; after release the first transfer appears on cycle 1.
- Select mode (RR_MODE=0, CHANNELS=4): sel=2, in_data ch2=16'hBEEF valid, out_ready=1 -> next cycle out_data=16'hBEEF, out_chan=2; sel=3'd5 on CHANNELS=5 grants nothing.
- Backpressure: hold out_ready=0 after one load of 16'h1234 -> out_data stays 16'h1234 and all in_ready=0 for 5 cycles; raise out_ready -> the next word loads on the same edge, with no bubble.
- Round-robin (RR_MODE=1): all 4 channels valid with words 16'h000i, out_ready=1 -> out_chan sequence 0,1,2,3,0 on consecutive cycles; with only ch1 and ch3 valid -> 1,3,1,3.
- Wrap/skip: ptr=3, only ch0 valid -> grant 0, ptr becomes 1.
- Stats (STREAM_MUX_STATS_EN): force 70000 grants on ch0 -> stat_sel=0 reads 16'hFFFF; stat_sel=1 reads 0; reset clears both to 0.
